// File: rtl/traffic_light_monitor.sv
// ----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker for a traffic-light controller's lamp outputs. Each clock it
// samples the three lamps and tracks the phase sequence RED -> GREEN -> YELLOW
// -> RED. It times each phase, flags encoding, ordering and duration faults,
// and counts completed light cycles.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   en           in   1   monitor enable (low: tracking suspended, FSM idles)
//   red_light    in   1   observed red lamp
//   yellow_light in   1   observed yellow lamp
//   green_light  in   1   observed green lamp
//   phase        out  2   tracked phase: 0 IDLE, 1 RED, 2 GREEN, 3 YELLOW
//   err_valid    out  1   one-cycle pulse per violation
//   err_code     out  3   violation code while err_valid, else 0
//   err_sticky   out  1   set on first violation, cleared by rst only
//   first_err    out  3   code of the first violation since rst
//   cycle_count  out  16  completed YELLOW->RED transitions (wrapping)
//
// Error codes: 1 MULTI, 2 ORDER, 3 SHORT, 4 LONG, 5 DARK.
// ----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int RED_MIN    = 8,
    parameter int RED_MAX    = 12,
    parameter int GREEN_MIN  = 6,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 4,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        red_light,
    input  logic        yellow_light,
    input  logic        green_light,
    output logic [1:0]  phase,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic        err_sticky,
    output logic [2:0]  first_err,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RED    = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } phase_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_MULTI = 3'd1;
    localparam logic [2:0] ERR_ORDER = 3'd2;
    localparam logic [2:0] ERR_SHORT = 3'd3;
    localparam logic [2:0] ERR_LONG  = 3'd4;
    localparam logic [2:0] ERR_DARK  = 3'd5;

    localparam logic [CNT_W-1:0] DUR_ZERO = '0;
    localparam logic [CNT_W-1:0] DUR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DUR_SAT  = '1;

    // State registers
    phase_t           r_phase;
    logic [CNT_W-1:0] r_dur;
    logic             r_first;        // current phase is partial: exempt from SHORT
    logic             r_err_valid;
    logic [2:0]       r_err_code;
    logic             r_err_sticky;
    logic [2:0]       r_first_err;
    logic [15:0]      r_cycle_count;

    // Next-state values
    phase_t           w_phase_next;
    logic [CNT_W-1:0] w_dur_next;
    logic             w_first_next;
    logic [2:0]       w_code;
    logic             w_err_next;
    logic [15:0]      w_cycle_next;

    // Sample classification
    logic             w_multi;
    logic             w_dark;
    phase_t           w_col;
    phase_t           w_succ;
    logic [CNT_W-1:0] w_min;
    logic [CNT_W-1:0] w_max;

    assign w_multi = (red_light & yellow_light) | (red_light & green_light) |
                     (yellow_light & green_light);
    assign w_dark  = ~(red_light | yellow_light | green_light);

    always_comb begin
        w_col = IDLE;
        if (red_light)         w_col = RED;
        else if (green_light)  w_col = GREEN;
        else if (yellow_light) w_col = YELLOW;
    end

    // Duration limits and legal successor of the phase currently tracked
    always_comb begin
        w_succ = IDLE;
        w_min  = DUR_ZERO;
        w_max  = DUR_SAT;
        case (r_phase)
            RED: begin
                w_succ = GREEN;
                w_min  = CNT_W'(RED_MIN);
                w_max  = CNT_W'(RED_MAX);
            end
            GREEN: begin
                w_succ = YELLOW;
                w_min  = CNT_W'(GREEN_MIN);
                w_max  = CNT_W'(GREEN_MAX);
            end
            YELLOW: begin
                w_succ = RED;
                w_min  = CNT_W'(YELLOW_MIN);
                w_max  = CNT_W'(YELLOW_MAX);
            end
            default: begin
                w_succ = IDLE;
            end
        endcase
    end

    // Phase FSM next-state and violation detection
    always_comb begin
        w_phase_next = r_phase;
        w_dur_next   = r_dur;
        w_first_next = r_first;
        w_code       = ERR_NONE;
        w_cycle_next = r_cycle_count;

        if (!en) begin
            w_phase_next = IDLE;
            w_dur_next   = DUR_ZERO;
        end else if (w_multi) begin
            w_code       = ERR_MULTI;
            w_phase_next = IDLE;
            w_dur_next   = DUR_ZERO;
        end else if (w_dark) begin
            // Darkness is only a fault while a phase is being tracked
            if (r_phase != IDLE) begin
                w_code = ERR_DARK;
            end
            w_phase_next = IDLE;
            w_dur_next   = DUR_ZERO;
        end else if (r_phase == IDLE) begin
            w_phase_next = w_col;
            w_dur_next   = DUR_ONE;
            w_first_next = 1'b1;
        end else if (w_col == r_phase) begin
            // dur passes MAX exactly once, so LONG fires once per phase;
            // saturating at all-ones keeps it from wrapping back onto MAX.
            if (r_dur == w_max) begin
                w_code = ERR_LONG;
            end
            if (r_dur != DUR_SAT) begin
                w_dur_next = r_dur + DUR_ONE;
            end
        end else if (w_col == w_succ) begin
            if ((r_dur < w_min) && !r_first) begin
                w_code = ERR_SHORT;
            end
            if (r_phase == YELLOW) begin
                w_cycle_next = r_cycle_count + 16'd1;
            end
            w_phase_next = w_col;
            w_dur_next   = DUR_ONE;
            w_first_next = 1'b0;
        end else begin
            // Resynchronise onto the observed colour; its length is unknown
            // relative to a proper entry, so treat it as a partial phase.
            w_code       = ERR_ORDER;
            w_phase_next = w_col;
            w_dur_next   = DUR_ONE;
            w_first_next = 1'b1;
        end

        w_err_next = (w_code != ERR_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase       <= IDLE;
            r_dur         <= DUR_ZERO;
            r_first       <= 1'b0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_err_sticky  <= 1'b0;
            r_first_err   <= ERR_NONE;
            r_cycle_count <= 16'd0;
        end else begin
            r_phase       <= w_phase_next;
            r_dur         <= w_dur_next;
            r_first       <= w_first_next;
            r_err_valid   <= w_err_next;
            r_err_code    <= w_code;
            r_cycle_count <= w_cycle_next;
            if (w_err_next) begin
                r_err_sticky <= 1'b1;
            end
            if (w_err_next && !r_err_sticky) begin
                r_first_err <= w_code;
            end
        end
    end

    assign phase       = r_phase;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
    assign err_sticky  = r_err_sticky;
    assign first_err   = r_first_err;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Scoreboard bench: each driven sample is run through a behavioural model and
// the expected outputs are queued; after the clock edge the entry is popped
// and compared with the monitor's registered outputs. Directed checks against
// hand-derived constants cover the scenario-level outcomes.
// ----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic        red_light;
    logic        yellow_light;
    logic        green_light;
    logic [1:0]  phase;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic [2:0]  first_err;
    logic [15:0] cycle_count;

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .red_light    (red_light),
        .yellow_light (yellow_light),
        .green_light  (green_light),
        .phase        (phase),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_sticky   (err_sticky),
        .first_err    (first_err),
        .cycle_count  (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0]  ph;
        logic        ev;
        logic [2:0]  ec;
        logic        st;
        logic [2:0]  fe;
        logic [15:0] cc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference state
    int m_ph    = 0;
    int m_dur   = 0;
    int m_first = 0;
    int m_st    = 0;
    int m_fe    = 0;
    int m_cc    = 0;
    int m_ev    = 0;
    int m_ec    = 0;

    int mn_tab[4]   = '{0, 8, 6, 2};
    int mx_tab[4]   = '{0, 12, 10, 4};
    int succ_tab[4] = '{0, 2, 3, 1};

    int pulse_cnt = 0;
    int pulse_at  = 0;
    int pulse_code = 0;
    int sample_idx = 0;
    int txn = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", tag, obs, exp, txn);
        end
    endtask

    task automatic model_step(input logic rs, input logic e, input logic r,
                              input logic y, input logic g);
        int lit;
        int col;
        lit = int'(r) + int'(y) + int'(g);
        col = r ? 1 : (g ? 2 : (y ? 3 : 0));
        m_ev = 0;
        m_ec = 0;
        if (rs) begin
            m_ph = 0; m_dur = 0; m_first = 0; m_st = 0; m_fe = 0; m_cc = 0;
        end else begin
            if (!e) begin
                m_ph = 0; m_dur = 0;
            end else if (lit > 1) begin
                m_ec = 1; m_ph = 0; m_dur = 0;
            end else if (lit == 0) begin
                if (m_ph != 0) m_ec = 5;
                m_ph = 0; m_dur = 0;
            end else if (m_ph == 0) begin
                m_ph = col; m_dur = 1; m_first = 1;
            end else if (col == m_ph) begin
                if (m_dur == mx_tab[m_ph]) m_ec = 4;
                if (m_dur < 255) m_dur++;
            end else if (col == succ_tab[m_ph]) begin
                if (m_dur < mn_tab[m_ph] && m_first == 0) m_ec = 3;
                if (m_ph == 3) m_cc = (m_cc + 1) % 65536;
                m_ph = col; m_dur = 1; m_first = 0;
            end else begin
                m_ec = 2; m_ph = col; m_dur = 1; m_first = 1;
            end
            if (m_ec != 0) begin
                m_ev = 1;
                if (m_st == 0) begin
                    m_fe = m_ec;
                    m_st = 1;
                end
            end
        end
    endtask

    // Drive one sample pattern for n cycles, scoreboarding every cycle
    task automatic drive(input logic rs, input logic e, input logic r,
                         input logic y, input logic g, input int n);
        exp_t ex;
        exp_t got;
        for (int k = 0; k < n; k++) begin
            rst = rs; en = e; red_light = r; yellow_light = y; green_light = g;
            model_step(rs, e, r, y, g);
            ex.ph = 2'(m_ph); ex.ev = 1'(m_ev); ex.ec = 3'(m_ec);
            ex.st = 1'(m_st); ex.fe = 3'(m_fe); ex.cc = 16'(m_cc);
            sb_q.push_back(ex);
            @(posedge clk);
            #1;
            txn++;
            got = sb_q.pop_front();
            $display("txn %0d rst=%0b en=%0b ryg=%0b%0b%0b -> phase=%0d ev=%0b code=%0d sticky=%0b first=%0d cc=%0d",
                     txn, rs, e, r, y, g, phase, err_valid, err_code, err_sticky, first_err, cycle_count);
            check("phase", 32'(phase), 32'(got.ph));
            check("err", {28'd0, err_valid, err_code}, {28'd0, got.ev, got.ec});
            check("status", {12'd0, err_sticky, first_err, cycle_count},
                  {12'd0, got.st, got.fe, got.cc});
            sample_idx++;
            if (err_valid) begin
                pulse_cnt++;
                pulse_at   = sample_idx;
                pulse_code = int'(err_code);
            end
        end
    endtask

    task automatic clear_pulses();
        pulse_cnt = 0; pulse_at = 0; pulse_code = 0; sample_idx = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        red_light = 1'b0; yellow_light = 1'b0; green_light = 1'b0;

        // Reset state
        drive(1, 0, 0, 0, 0, 2);
        check("rst_outputs", {22'd0, phase, err_valid, err_code, err_sticky, first_err},
              32'd0);
        check("rst_cc", 32'(cycle_count), 32'd0);

        // Nominal: three clean cycles
        clear_pulses();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 1, 0, 0, 10);
            drive(0, 1, 0, 0, 1, 8);
            drive(0, 1, 0, 1, 0, 3);
        end
        drive(0, 1, 1, 0, 0, 1);
        check("nom_cc", 32'(cycle_count), 32'd3);
        check("nom_pulses", 32'(pulse_cnt), 32'd0);
        check("nom_sticky", 32'(err_sticky), 32'd0);

        // Short yellow: SHORT reported with the RED sample that ends it
        drive(0, 1, 1, 0, 0, 9);
        drive(0, 1, 0, 0, 1, 8);
        drive(0, 1, 0, 1, 0, 1);
        drive(0, 1, 1, 0, 0, 1);
        check("short_code", {28'd0, err_valid, err_code}, 32'h0000_000B);
        check("short_first", 32'(first_err), 32'd3);
        check("short_sticky", 32'(err_sticky), 32'd1);
        check("short_cc", 32'(cycle_count), 32'd4);

        // Long green: single LONG pulse on the 11th GREEN sample
        drive(0, 1, 1, 0, 0, 9);
        clear_pulses();
        drive(0, 1, 0, 0, 1, 14);
        check("long_pulses", 32'(pulse_cnt), 32'd1);
        check("long_at", 32'(pulse_at), 32'd11);
        check("long_code", 32'(pulse_code), 32'd4);
        drive(0, 1, 0, 1, 0, 3);
        drive(0, 1, 1, 0, 0, 3);
        check("long_cc", 32'(cycle_count), 32'd5);

        // Reset mid-RED with sticky set and cycle_count=5
        check("pre_rst_sticky", 32'(err_sticky), 32'd1);
        drive(1, 1, 1, 0, 0, 1);
        check("midrst_outputs", {22'd0, phase, err_valid, err_code, err_sticky, first_err},
              32'd0);
        check("midrst_cc", 32'(cycle_count), 32'd0);
        clear_pulses();
        drive(0, 1, 0, 0, 1, 2);
        drive(0, 1, 0, 1, 0, 3);
        check("restart_pulses", 32'(pulse_cnt), 32'd0);
        check("restart_phase", 32'(phase), 32'd3);

        // Order then encoding, from a fresh reset
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 1, 1, 0, 0, 5);
        drive(0, 1, 0, 1, 0, 1);
        check("order_code", {28'd0, err_valid, err_code}, 32'h0000_000A);
        check("order_phase", 32'(phase), 32'd3);
        drive(0, 1, 1, 0, 1, 1);
        check("multi_code", {28'd0, err_valid, err_code}, 32'h0000_0009);
        check("multi_phase", 32'(phase), 32'd0);
        check("multi_first", 32'(first_err), 32'd2);

        // Dark while tracking, then the same with en low
        drive(0, 1, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1, 3);
        drive(0, 1, 0, 0, 0, 1);
        check("dark_code", {28'd0, err_valid, err_code}, 32'h0000_000D);
        check("dark_phase", 32'(phase), 32'd0);
        drive(0, 1, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1, 3);
        clear_pulses();
        drive(0, 0, 0, 0, 0, 2);
        check("den_pulses", 32'(pulse_cnt), 32'd0);
        check("den_phase", 32'(phase), 32'd0);
        check("den_cc", 32'(cycle_count), 32'd0);
        check("den_first", 32'(first_err), 32'd2);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
